// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the round-robin RAM scheduler.
package mem_sched_pkg;

    // Scheduler FSM states; DELIVER is a spare encoding that is never entered
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        DELIVER   = 2'd3
    } sched_state_t;

    // Per-core rw encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Default RAM geometry
    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/mem_scheduler_rr_picker.sv
// Combinational round-robin picker: finds the first requesting core after rr_ptr.
module rr_picker #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     winner
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_CORES; the last winner is checked last
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CORES)) begin
                sum = sum - (IDX_W+1)'(NUM_CORES);
            end
            idx = sum[IDX_W-1:0];
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// Round-robin scheduler sharing one single-port RAM between NUM_CORES requesters.
// All outputs are registered; reset is asynchronous and active-low.
module mem_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        rw,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           RAM_address,
    output logic [DATA_W-1:0]           RAM_data_in,
    input  logic [DATA_W-1:0]           RAM_data_out,
    output logic                        RAM_rw
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = 3;

    sched_state_t          state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]      op_core, op_core_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_CORES-1:0]  grant_nxt, done_nxt;
    logic [DATA_W-1:0]     rdata_nxt;
    logic                  busy_nxt;
    logic [ADDR_W-1:0]     ram_address_nxt;
    logic [DATA_W-1:0]     ram_data_in_nxt;
    logic                  ram_rw_nxt;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Next-state and next-output logic. The read counter is loaded with RD_LATENCY
    // when the address is launched and the data is captured in the cycle the counter
    // reaches zero, i.e. RD_LATENCY cycles after the address first appears on the RAM.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        op_core_nxt     = op_core;
        cnt_nxt         = cnt;
        grant_nxt       = '0;
        done_nxt        = '0;
        rdata_nxt       = rdata;
        ram_address_nxt = RAM_address;
        ram_data_in_nxt = RAM_data_in;
        ram_rw_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_nxt[pick_idx] = 1'b1;
                    rr_ptr_nxt          = pick_idx;
                    op_core_nxt         = pick_idx;
                    ram_address_nxt     = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    if (rw[pick_idx] == RW_WRITE) begin
                        ram_data_in_nxt = wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        ram_rw_nxt      = 1'b1;
                        state_nxt       = WRITE;
                    end else begin
                        cnt_nxt   = CNT_W'(RD_LATENCY);
                        state_nxt = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                done_nxt[op_core] = 1'b1;
                state_nxt         = IDLE;
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    rdata_nxt         = RAM_data_out;
                    done_nxt[op_core] = 1'b1;
                    state_nxt         = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset aborts any transaction and drops the write strobe at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(NUM_CORES - 1);
            op_core     <= '0;
            cnt         <= '0;
            grant       <= '0;
            done        <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            RAM_address <= '0;
            RAM_data_in <= '0;
            RAM_rw      <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            op_core     <= op_core_nxt;
            cnt         <= cnt_nxt;
            grant       <= grant_nxt;
            done        <= done_nxt;
            rdata       <= rdata_nxt;
            busy        <= busy_nxt;
            RAM_address <= ram_address_nxt;
            RAM_data_in <= ram_data_in_nxt;
            RAM_rw      <= ram_rw_nxt;
        end
    end

endmodule
